// File: rtl/stream_dmux.sv
// Stream demultiplexer: routes one input word to one channel (or to all channels
// when broadcasting) through per-channel one-entry output registers.
module stream_dmux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_cnt
);

  // Wide enough to compare any select value against CHANNELS (up to 16).
  localparam int unsigned CMP_W = SEL_W + 6;

  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [7:0]                drop_q, drop_d;

  logic [CHANNELS-1:0] free_c;
  logic [CHANNELS-1:0] tgt_c;
  logic [CHANNELS-1:0] load_c;
  logic                in_range_c;
  logic                accept_c;
  logic                drop_c;

  // Target decode and handshake; in_ready never looks at in_valid.
  always_comb begin
    in_range_c = CMP_W'(in_sel) < CMP_W'(CHANNELS);
    free_c     = ~valid_q | out_ready;
    tgt_c      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      tgt_c[i] = in_bcast | (CMP_W'(in_sel) == CMP_W'(i));
    end
    if (reset) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &free_c;
    end else if (!in_range_c) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(tgt_c & free_c);
    end
    accept_c = in_valid & in_ready;
    load_c   = accept_c ? tgt_c : '0;
    drop_c   = accept_c & ~in_bcast & ~in_range_c;
  end

  // Slot update: a refill wins over a drain, so a busy channel streams at full rate.
  always_comb begin
    valid_d = load_c | (valid_q & ~out_ready);
    data_d  = data_q;
    drop_d  = drop_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (load_c[i]) begin
        data_d[i*WIDTH +: WIDTH] = in_data;
      end
    end
    if (drop_c && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_dmux.sv
// Scoreboard bench for stream_dmux: a 4-channel instance for routing/backpressure
// and a 3-channel instance for out-of-range drops.
module tb_stream_dmux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast, in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic [7:0]  drop_cnt;

  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_bcast3, in_valid3, in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3, out_ready3;
  logic [7:0]  drop_cnt3;

  stream_dmux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  stream_dmux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
    .in_bcast(in_bcast3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .drop_cnt(drop_cnt3)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_deliv = 0;
  int d0;
  logic [7:0] exp_q [4][$];
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] sel, input logic bc, input logic [7:0] d);
    if (bc) begin
      for (int c = 0; c < 4; c++) exp_q[c].push_back(d);
    end else begin
      exp_q[sel].push_back(d);
    end
  endtask

  // Offer a word until accepted (bounded); returns just after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic bc, input logic [7:0] d);
    bit done = 1'b0;
    in_sel = sel; in_bcast = bc; in_data = d; in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(sel, bc, d);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: word %0h never accepted at %0t", d, $time);
    end
  endtask

  // Monitor: every channel transfer on the 4-channel instance is checked in order.
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_out: ch%0d data %0h with empty queue at %0t",
                     c, out_data[c*8 +: 8], $time);
          end else begin
            mon_e = exp_q[c].pop_front();
            check($sformatf("ch%0d_data", c), 32'(out_data[c*8 +: 8]), 32'(mon_e));
            n_deliv++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_data = 8'hEE; in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
    out_ready = 4'h0;
    in_data3 = 8'hEE; in_sel3 = 2'd0; in_bcast3 = 1'b0; in_valid3 = 1'b1;
    out_ready3 = 3'h0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_ready4", 32'(in_ready), 32'd0);
    check("rst_ready3", 32'(in_ready3), 32'd0);
    check("rst_valid4", 32'(out_valid), 32'd0);
    check("rst_data4", out_data, 32'd0);
    check("rst_drop4", 32'(drop_cnt), 32'd0);
    check("rst_drop3", 32'(drop_cnt3), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;

    // Unicast to channel 2
    out_ready = 4'hF;
    send(2'd2, 1'b0, 8'hA5);
    check("uc_valid", 32'(out_valid), 32'h4);
    check("uc_data", 32'(out_data[23:16]), 32'hA5);
    @(posedge clk); #1;
    check("uc_clear", 32'(out_valid), 32'h0);

    // Backpressure on channel 1, then drain+refill in one cycle
    out_ready = 4'b1101;
    send(2'd1, 1'b0, 8'h11);
    check("bp_first_valid", 32'(out_valid), 32'h2);
    in_sel = 2'd1; in_data = 8'h22; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_data[15:8]), 32'h11);
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_ready_high", 32'(in_ready), 32'd1);
    push_exp(2'd1, 1'b0, 8'h22);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_refill_valid", 32'(out_valid), 32'h2);
    check("bp_refill_data", 32'(out_data[15:8]), 32'h22);
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'h0);

    // Broadcast into empty slots
    out_ready = 4'hF;
    send(2'd0, 1'b1, 8'h3C);
    check("bc_valid", 32'(out_valid), 32'hF);
    check("bc_data", out_data, 32'h3C3C3C3C);
    @(posedge clk); #1;
    check("bc_clear", 32'(out_valid), 32'h0);

    // Broadcast blocked by a stalled channel 3
    out_ready = 4'b0111;
    send(2'd3, 1'b0, 8'h44);
    check("bcs_ch3_loaded", 32'(out_valid), 32'h8);
    in_bcast = 1'b1; in_data = 8'h55; in_sel = 2'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bcs_ready_low", 32'(in_ready), 32'd0);
      check("bcs_no_partial", 32'(out_valid), 32'h8);
      @(posedge clk); #1;
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    check("bcs_ready_high", 32'(in_ready), 32'd1);
    push_exp(2'd0, 1'b1, 8'h55);
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0;
    check("bcs_valid", 32'(out_valid), 32'hF);
    check("bcs_data", out_data, 32'h55555555);
    @(posedge clk); #1;
    check("bcs_clear", 32'(out_valid), 32'h0);

    // Out-of-range drops on the 3-channel instance, saturating at 255
    out_ready3 = 3'b111; in_sel3 = 2'd3; in_data3 = 8'h5A; in_valid3 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      check("drop_ready", 32'(in_ready3), 32'd1);
      check("drop_no_valid", 32'(out_valid3), 32'd0);
      check("drop_cnt", 32'(drop_cnt3), (k < 255) ? 32'(k) : 32'd255);
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    @(negedge clk);
    check("drop_final", 32'(drop_cnt3), 32'd255);
    @(posedge clk); #1;

    // In-range unicast on the 3-channel instance
    out_ready3 = 3'b000; in_sel3 = 2'd2; in_data3 = 8'h99; in_valid3 = 1'b1;
    @(negedge clk);
    check("c3_ready", 32'(in_ready3), 32'd1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    check("c3_valid", 32'(out_valid3), 32'h4);
    check("c3_data", 32'(out_data3[23:16]), 32'h99);
    check("c3_drop_kept", 32'(drop_cnt3), 32'd255);

    // Reset mid-stream discards held words
    out_ready = 4'h0;
    send(2'd0, 1'b0, 8'h66);
    send(2'd1, 1'b0, 8'h77);
    check("mrst_loaded", 32'(out_valid), 32'h3);
    reset = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h88;
    in_valid3 = 1'b1; in_sel3 = 2'd0;
    @(negedge clk);
    check("mrst_ready4", 32'(in_ready), 32'd0);
    check("mrst_ready3", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    check("mrst_valid4", 32'(out_valid), 32'd0);
    check("mrst_data4", out_data, 32'd0);
    check("mrst_drop4", 32'(drop_cnt), 32'd0);
    check("mrst_valid3", 32'(out_valid3), 32'd0);
    check("mrst_data3", 32'(out_data3), 32'd0);
    check("mrst_drop3", 32'(drop_cnt3), 32'd0);
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    reset = 1'b0; in_valid3 = 1'b0;
    out_ready = 4'hF;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    push_exp(2'd2, 1'b0, 8'h88);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'h4);
    @(posedge clk); #1;

    // Streaming 64 words round-robin at full rate
    d0 = n_deliv;
    out_ready = 4'hF; in_bcast = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_sel  = 2'(i);
      in_data = 8'(i * 3 + 1);
      @(negedge clk);
      check("stream_ready", 32'(in_ready), 32'd1);
      if (in_ready) push_exp(in_sel, 1'b0, in_data);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_delivered", 32'(n_deliv - d0), 32'd64);

    for (int c = 0; c < 4; c++) begin
      check($sformatf("q%0d_empty", c), 32'(exp_q[c].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
